// File: rtl/rx_byte_fifo.sv
// rtl/rx_byte_fifo.sv - elastic byte FIFO with block-RAM storage and a prefetched output register
module rx_byte_fifo #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_Wr_DV,
    input  logic [DATA_W-1:0]     i_Wr_Byte,
    output logic                  o_Rd_Valid,
    output logic [DATA_W-1:0]     o_Rd_Byte,
    input  logic                  i_Rd_Ready,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic                  o_Overflow,
    input  logic                  i_Clr_Ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CAP = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE = (DEPTH_LOG2+1)'(1);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_VALID} state_t;

    state_t                state, state_n;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     ram_q;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   mem_cnt, mem_cnt_n, count_n;
    logic                  wr_acc, handshake, rd_issue, mem_avail;

    // Full check is on the registered flag only; a same-cycle read does not make room.
    assign wr_acc     = reset & i_Wr_DV & ~o_Full;
    assign o_Rd_Valid = (state == S_VALID);
    assign handshake  = o_Rd_Valid & i_Rd_Ready;
    assign mem_avail  = (mem_cnt != '0);

    always_comb begin
        state_n  = state;
        rd_issue = 1'b0;
        case (state)
            S_EMPTY: begin
                if (mem_avail) begin
                    rd_issue = 1'b1;
                    state_n  = S_LOAD;
                end
            end
            S_LOAD: state_n = S_VALID;
            S_VALID: begin
                if (handshake) begin
                    if (mem_avail) begin
                        rd_issue = 1'b1;
                        state_n  = S_LOAD;
                    end else begin
                        state_n  = S_EMPTY;
                    end
                end
            end
            default: state_n = S_EMPTY;
        endcase
    end

    always_comb begin
        count_n = o_Count;
        if (wr_acc && !handshake)
            count_n = o_Count + ONE;
        else if (!wr_acc && handshake)
            count_n = o_Count - ONE;

        mem_cnt_n = mem_cnt;
        if (wr_acc && !rd_issue)
            mem_cnt_n = mem_cnt + ONE;
        else if (!wr_acc && rd_issue)
            mem_cnt_n = mem_cnt - ONE;
    end

    // Storage is left unreset so it maps onto block RAM with a registered read port.
    always_ff @(posedge clock) begin
        if (wr_acc)
            mem[wr_ptr] <= i_Wr_Byte;
        if (rd_issue && reset)
            ram_q <= mem[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_EMPTY;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            o_Count    <= '0;
            o_Full     <= 1'b0;
            o_Empty    <= 1'b1;
            o_Overflow <= 1'b0;
            o_Rd_Byte  <= '0;
        end else begin
            state   <= state_n;
            mem_cnt <= mem_cnt_n;
            o_Count <= count_n;
            o_Full  <= (count_n == CAP);
            o_Empty <= (count_n == '0);
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue)
                rd_ptr <= rd_ptr + 1'b1;
            if (state == S_LOAD)
                o_Rd_Byte <= ram_q;
            if (i_Wr_DV && o_Full)
                o_Overflow <= 1'b1;
            else if (i_Clr_Ovf)
                o_Overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb/tb_rx_byte_fifo.sv - randomized self-checking bench for rx_byte_fifo against a queue model
module tb_rx_byte_fifo;

    localparam int DL  = 4;
    localparam int CAP = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_Wr_DV = 1'b0;
    logic [7:0]    i_Wr_Byte = '0;
    logic          o_Rd_Valid;
    logic [7:0]    o_Rd_Byte;
    logic          i_Rd_Ready = 1'b0;
    logic [DL:0]   o_Count;
    logic          o_Full, o_Empty, o_Overflow;
    logic          i_Clr_Ovf = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;

    rx_byte_fifo #(.DEPTH_LOG2(DL), .DATA_W(8)) dut (
        .clock(clock), .reset(reset), .i_Wr_DV(i_Wr_DV), .i_Wr_Byte(i_Wr_Byte),
        .o_Rd_Valid(o_Rd_Valid), .o_Rd_Byte(o_Rd_Byte), .i_Rd_Ready(i_Rd_Ready),
        .o_Count(o_Count), .o_Full(o_Full), .o_Empty(o_Empty),
        .o_Overflow(o_Overflow), .i_Clr_Ovf(i_Clr_Ovf)
    );

    always #5 clock = ~clock;

    // Drives one clock edge and advances the model; returns whether a handshake happened
    // along with the byte seen and the byte the model expected at the head.
    task automatic cycle(input logic rst_n, input logic wr, input logic [7:0] b,
                         input logic rdy, input logic clr,
                         output logic hs, output logic [7:0] got, output logic [7:0] exp);
        logic was_full;
        reset = rst_n; i_Wr_DV = wr; i_Wr_Byte = b; i_Rd_Ready = rdy; i_Clr_Ovf = clr;
        #1;
        hs  = rst_n & o_Rd_Valid & rdy;
        got = o_Rd_Byte;
        exp = (q.size() > 0) ? q[0] : 8'hxx;
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            was_full = (q.size() == CAP);
            if (hs && q.size() > 0) void'(q.pop_front());
            if (wr && !was_full) q.push_back(b);
            if (wr && was_full) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        @(posedge clock);
        #1;
        i_Wr_DV = 1'b0; i_Clr_Ovf = 1'b0;
    endtask

    task automatic test_reset();
        logic hs; logic [7:0] g, e;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, hs, g, e);
        n_cmp++; if (o_Count !== 0)      begin n_err++; $display("FAIL reset_count got %0d want 0", o_Count); end
        n_cmp++; if (o_Empty !== 1'b1)   begin n_err++; $display("FAIL reset_empty got %b want 1", o_Empty); end
        n_cmp++; if (o_Full !== 1'b0)    begin n_err++; $display("FAIL reset_full got %b want 0", o_Full); end
        n_cmp++; if (o_Rd_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o_Rd_Valid); end
        n_cmp++; if (o_Overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", o_Overflow); end
        n_cmp++; if (o_Rd_Byte !== 8'h00) begin n_err++; $display("FAIL reset_byte got %h want 00", o_Rd_Byte); end
    endtask

    task automatic drain(input string name, input int budget);
        logic hs; logic [7:0] g, e;
        int left;
        left = budget;
        while (q.size() > 0 && left > 0) begin
            cycle(1'b1, 1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0, hs, g, e);
            if (hs) begin
                n_cmp++; if (g !== e) begin n_err++; $display("FAIL %s_byte got %h want %h", name, g, e); end
            end
            left--;
        end
        n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL %s_timeout left %0d want 0", name, q.size()); end
        n_cmp++; if (o_Empty !== 1'b1 || o_Count !== 0)
            begin n_err++; $display("FAIL %s_empty got %b/%0d want 1/0", name, o_Empty, o_Count); end
    endtask

    task automatic test_latency();
        logic hs; logic [7:0] g, e;
        cycle(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, hs, g, e);
        n_cmp++; if (o_Rd_Valid !== 1'b0) begin n_err++; $display("FAIL lat_n1_valid got %b want 0", o_Rd_Valid); end
        n_cmp++; if (o_Count !== 1)      begin n_err++; $display("FAIL lat_count got %0d want 1", o_Count); end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, hs, g, e);
        n_cmp++; if (o_Rd_Valid !== 1'b0) begin n_err++; $display("FAIL lat_n1b_valid got %b want 0", o_Rd_Valid); end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, hs, g, e);
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (o_Rd_Valid !== 1'b1 || o_Rd_Byte !== 8'hA5)
                begin n_err++; $display("FAIL lat_hold%0d got %b/%h want 1/a5", i, o_Rd_Valid, o_Rd_Byte); end
            cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, hs, g, e);
        end
        drain("lat", 50);
    endtask

    task automatic test_overflow();
        logic hs; logic [7:0] g, e;
        logic [7:0] seen[$];
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, hs, g, e);
        cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, hs, g, e);
        n_cmp++; if (o_Full !== 1'b1)     begin n_err++; $display("FAIL ovf_full got %b want 1", o_Full); end
        n_cmp++; if (o_Count !== 16)      begin n_err++; $display("FAIL ovf_count got %0d want 16", o_Count); end
        n_cmp++; if (o_Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", o_Overflow); end
        for (int i = 0; i < 60 && seen.size() < 17; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, hs, g, e);
            if (hs) seen.push_back(g);
            if (q.size() == 0 && o_Empty) break;
        end
        n_cmp++; if (seen.size() != 16) begin n_err++; $display("FAIL ovf_drain_n got %0d want 16", seen.size()); end
        for (int i = 0; i < seen.size() && i < 16; i++) begin
            n_cmp++; if (seen[i] !== 8'(i)) begin n_err++; $display("FAIL ovf_drain%0d got %h want %h", i, seen[i], 8'(i)); end
        end
        n_cmp++; if (o_Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", o_Overflow); end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, hs, g, e);
        n_cmp++; if (o_Overflow !== m_ovf) begin n_err++; $display("FAIL ovf_clr got %b want %b", o_Overflow, m_ovf); end
    endtask

    task automatic test_full_same_cycle();
        logic hs; logic [7:0] g, e;
        int t;
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, hs, g, e);
        t = 0;
        while (!o_Rd_Valid && t < 10) begin cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, hs, g, e); t++; end
        cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, hs, g, e);
        n_cmp++; if (!hs || g !== e) begin n_err++; $display("FAIL fullrd_hs got %b/%h want 1/%h", hs, g, e); end
        n_cmp++; if (o_Count !== 8'(q.size()) || q.size() != 15)
            begin n_err++; $display("FAIL fullrd_count got %0d want 15", o_Count); end
        n_cmp++; if (o_Overflow !== 1'b1) begin n_err++; $display("FAIL fullrd_ovf got %b want 1", o_Overflow); end
        n_cmp++; if (o_Full !== 1'b0)     begin n_err++; $display("FAIL fullrd_full got %b want 0", o_Full); end
        drain("fullrd", 200);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, hs, g, e);
    endtask

    task automatic test_wrap_stream();
        logic hs; logic [7:0] g, e;
        int sent, rcvd, gap, budget;
        sent = 0; rcvd = 0; gap = 0; budget = 2000;
        while (rcvd < 40 && budget > 0) begin
            logic wr;
            wr = (sent < 40) && (gap == 0) && (q.size() < CAP);
            cycle(1'b1, wr, 8'h10 + 8'(sent), 1'($urandom_range(0, 1)), 1'b0, hs, g, e);
            if (wr) begin sent++; gap = $urandom_range(0, 3); end
            else if (gap > 0) gap--;
            if (hs) begin
                n_cmp++; if (g !== 8'h10 + 8'(rcvd)) begin n_err++; $display("FAIL wrap_byte%0d got %h want %h", rcvd, g, 8'h10 + 8'(rcvd)); end
                rcvd++;
            end
            n_cmp++; if (o_Count !== 5'(q.size()) || o_Empty !== (q.size() == 0) || o_Full !== (q.size() == CAP))
                begin n_err++; $display("FAIL wrap_occ got %0d/%b/%b want %0d", o_Count, o_Empty, o_Full, q.size()); end
            budget--;
        end
        n_cmp++; if (rcvd != 40)          begin n_err++; $display("FAIL wrap_total got %0d want 40", rcvd); end
        n_cmp++; if (o_Overflow !== 1'b0) begin n_err++; $display("FAIL wrap_ovf got %b want 0", o_Overflow); end
    endtask

    task automatic test_reset_midread();
        logic hs; logic [7:0] g, e;
        int t;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, hs, g, e);
        t = 0;
        while (!o_Rd_Valid && t < 10) begin cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, hs, g, e); t++; end
        cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, hs, g, e);
        n_cmp++; if (o_Count !== 7) begin n_err++; $display("FAIL rstmid_pre got %0d want 7", o_Count); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, hs, g, e);
        n_cmp++; if (o_Count !== 0 || o_Rd_Valid !== 1'b0 || o_Empty !== 1'b1)
            begin n_err++; $display("FAIL rstmid_clear got %0d/%b/%b want 0/0/1", o_Count, o_Rd_Valid, o_Empty); end
        cycle(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, hs, g, e);
        t = 0;
        while (!o_Rd_Valid && t < 10) begin cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, hs, g, e); t++; end
        n_cmp++; if (o_Rd_Valid !== 1'b1 || o_Rd_Byte !== 8'h3C)
            begin n_err++; $display("FAIL rstmid_first got %b/%h want 1/3c", o_Rd_Valid, o_Rd_Byte); end
        drain("rstmid", 50);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_full_same_cycle();
        test_wrap_stream();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
